// File: rtl/bandit_pkg.sv
// bandit_pkg: shared action/reward types, environment state codes and reward saturation
package bandit_pkg;
    typedef logic [7:0] action_t;
    typedef logic signed [7:0] reward_t;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOOKUP = 2'd1;
    localparam logic [1:0] S_REPORT = 2'd2;
    // Overflow of a 9-bit sum into 8 bits shows up as the top two bits disagreeing
    function automatic reward_t sat_reward(input logic signed [8:0] sum);
        return (sum[8] != sum[7]) ? (sum[8] ? 8'sh80 : 8'sh7f) : reward_t'(sum[7:0]);
    endfunction
endpackage

// File: rtl/bandit_lfsr.sv
// bandit_lfsr: Fibonacci LFSR, shifts left with the XOR of the tapped bits entering bit 0
module bandit_lfsr #(
    parameter int              WIDTH = 8,
    parameter logic [WIDTH-1:0] SEED = '1,
    parameter logic [WIDTH-1:0] TAPS = 8'hb1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             advance,
    output logic [WIDTH-1:0] value
);
    always_ff @(posedge clock) begin
        if (reset) value <= SEED;
        else if (advance) value <= {value[WIDTH-2:0], ^(value & TAPS)};
    end
endmodule

// File: rtl/bandit_environment.sv
// bandit_environment: stationary bandit, reward = sat(mean[arm] + noise).
// Noise from an LFSR only when BANDIT_ENV_NOISE_EN is defined; otherwise reward = mean exactly.
module bandit_environment
    import bandit_pkg::*;
#(
    parameter logic [7:0] SEED        = 8'hff,
    parameter logic [7:0] TAPS        = 8'hb1,
    parameter int         NOISE_SHIFT = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        action_valid,
    input  action_t     action_data,
    output logic        action_ready,
    output logic        reward_valid,
    output reward_t     reward_data,
    input  logic        reward_ready,
    input  logic        config_valid,
    input  action_t     config_index,
    input  reward_t     config_data,
    output logic        config_ready,
    output logic [15:0] step_count
);
    logic [1:0] state, state_next;
    reward_t mem [256];
    reward_t mean;
    reward_t noise;
    logic signed [8:0] sum;
    logic act_fire, cfg_fire, rew_fire;

    assign act_fire = action_valid & action_ready;
    assign cfg_fire = config_valid & config_ready;
    assign rew_fire = reward_valid & reward_ready;

`ifdef BANDIT_ENV_NOISE_EN
    logic [7:0] lfsr;
    bandit_lfsr #(.WIDTH(8), .SEED(SEED), .TAPS(TAPS)) u_lfsr (
        .clock  (clock),
        .reset  (reset),
        .advance(1'b1),
        .value  (lfsr)
    );
    assign noise = $signed(lfsr) >>> NOISE_SHIFT;
`else
    logic unused_cfg;
    assign unused_cfg = ^{SEED, TAPS, NOISE_SHIFT[0]};
    assign noise = '0;
`endif

    assign sum = {mean[7], mean} + {noise[7], noise};

    // Table has no reset so it maps onto block RAM; the read register sees the pre-write value
    always_ff @(posedge clock) begin
        if (cfg_fire) mem[config_index] <= config_data;
        if (act_fire) mean <= mem[action_data];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            reward_data <= '0;
            step_count  <= '0;
        end else begin
            state <= state_next;
            if (state == S_LOOKUP) reward_data <= sat_reward(sum);
            if (rew_fire) step_count <= step_count + 16'd1;
        end
    end

    always_comb begin
        action_ready = state == S_IDLE;
        config_ready = state == S_IDLE;
        reward_valid = state == S_REPORT;
        state_next   = (state == S_IDLE)   ? (action_valid ? S_LOOKUP : S_IDLE) :
                       (state == S_LOOKUP) ? S_REPORT :
                       (state == S_REPORT) ? (reward_ready ? S_IDLE : S_REPORT) : S_IDLE;
    end
endmodule

// File: tb/tb_bandit_environment.sv
// tb_bandit_environment: randomized pulls checked by a queue scoreboard against an integer reward model
module tb_bandit_environment;
    localparam logic [7:0] SEED = 8'hff;
    localparam logic [7:0] TAPS = 8'hb1;
    localparam int NS = 0;

    logic clock = 0, reset = 1;
    logic action_valid = 0, reward_ready = 0, config_valid = 0;
    logic [7:0] action_data = 0, config_index = 0, config_data = 0;
    logic action_ready, reward_valid, config_ready;
    logic [7:0] reward_data;
    logic [15:0] step_count;

    always #5 clock = ~clock;

    bandit_environment #(.SEED(SEED), .TAPS(TAPS), .NOISE_SHIFT(NS)) dut (
        .clock(clock), .reset(reset),
        .action_valid(action_valid), .action_data(action_data), .action_ready(action_ready),
        .reward_valid(reward_valid), .reward_data(reward_data), .reward_ready(reward_ready),
        .config_valid(config_valid), .config_index(config_index), .config_data(config_data),
        .config_ready(config_ready), .step_count(step_count)
    );

    int checks = 0, errors = 0, cyc = 0, m_steps = 0, fire_cyc = -1;
    int exp_q[$];
    int m_mean[256];
    logic [7:0] m_lfsr = 8'h00;
    logic prev_valid = 0;
    bit seen_max = 0, seen_min = 0;

    task automatic check(input string name, input integer act, input integer exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] lstep(input logic [7:0] v);
        return {v[6:0], ^(v & TAPS)};
    endfunction

    // Floor division of the signed LFSR value gives the arithmetic shift; clamp to 8-bit range
    function automatic int model_reward(input int mean, input logic [7:0] lf);
        int n, s;
        n = int'(lf);
        if (n > 127) n -= 256;
`ifdef BANDIT_ENV_NOISE_EN
        n = (n >= 0) ? n / (1 << NS) : -((-n + (1 << NS) - 1) / (1 << NS));
`else
        n = 0;
`endif
        s = mean + n;
        return s > 127 ? 127 : (s < -128 ? -128 : s);
    endfunction

    always @(posedge clock) begin
        cyc <= cyc + 1;
        m_lfsr <= reset ? SEED : lstep(m_lfsr);
    end

    always @(negedge clock) begin
        if (reset) begin
            exp_q.delete();
            m_steps = 0;
            fire_cyc = -1;
            prev_valid = 0;
        end else begin
            if (reward_valid) begin
                check("readies_low_in_report", {action_ready, config_ready}, 0);
                if (exp_q.size() == 0) check("unexpected_reward", 1, 0);
                else check("reward_data", $signed(reward_data), exp_q[0]);
                if (!prev_valid && fire_cyc >= 0) check("latency", cyc - fire_cyc, 2);
                if (reward_ready && exp_q.size() != 0) begin
                    check("step_count", step_count, m_steps & 16'hffff);
                    if (exp_q[0] == 127) seen_max = 1;
                    if (exp_q[0] == -128) seen_min = 1;
                    void'(exp_q.pop_front());
                    m_steps++;
                end
            end
            prev_valid = reward_valid;
            if (action_valid && action_ready) begin
                exp_q.push_back(model_reward(m_mean[action_data], lstep(m_lfsr)));
                fire_cyc = cyc;
            end
            if (config_valid && config_ready) m_mean[config_index] = int'($signed(config_data));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!action_ready && n < 50) begin
            tick();
            n++;
        end
        if (!action_ready) check("idle_timeout", 0, 1);
    endtask

    task automatic wait_reward();
        int n = 0;
        while (!reward_valid && n < 20) begin
            tick();
            n++;
        end
        if (!reward_valid) check("reward_timeout", 0, 1);
    endtask

    task automatic configure(input logic [7:0] arm, input logic [7:0] mean);
        wait_idle();
        config_valid = 1;
        config_index = arm;
        config_data = mean;
        tick();
        config_valid = 0;
    endtask

    task automatic pull(input logic [7:0] arm, input int hold, input bit cfg, input logic [7:0] cdata);
        wait_idle();
        action_valid = 1;
        action_data = arm;
        config_valid = cfg;
        config_index = arm;
        config_data = cdata;
        tick();
        action_valid = 0;
        config_valid = 0;
        wait_reward();
        repeat (hold) tick();
        reward_ready = 1;
        tick();
        reward_ready = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        foreach (m_mean[i]) m_mean[i] = 0;
        repeat (2) tick();
        check("rst_action_ready", action_ready, 1);
        check("rst_config_ready", config_ready, 1);
        check("rst_reward_valid", reward_valid, 0);
        check("rst_reward_data", reward_data, 0);
        check("rst_step_count", step_count, 0);
        reset = 0;
        tick();
        configure(8'd5, 8'd40);
        pull(8'd5, 0, 0, 8'd0);
        check("step_after_first", step_count, 1);
        pull(8'd5, 4, 0, 8'd0);
        configure(8'd0, 8'd120);
        configure(8'd1, 8'h88);
        configure(8'd2, 8'($urandom_range(0, 255)));
        configure(8'd3, 8'($urandom_range(0, 255)));
        for (int i = 0; i < 1000; i++)
            pull(8'($urandom_range(0, 3)), $urandom_range(0, 2), 0, 8'd0);
        configure(8'd9, 8'd10);
        pull(8'd9, 0, 1, 8'd20);
        pull(8'd9, 1, 0, 8'd0);
        wait_idle();
        action_valid = 1;
        action_data = 8'd9;
        tick();
        action_valid = 0;
        wait_reward();
        reset = 1;
        tick();
        check("mid_reset_reward_valid", reward_valid, 0);
        check("mid_reset_step_count", step_count, 0);
        check("mid_reset_reward_data", reward_data, 0);
        reset = 0;
        tick();
        pull(8'd9, 0, 0, 8'd0);
        repeat (3) tick();
        check("final_step_count", step_count, m_steps & 16'hffff);
        check("queue_drained", exp_q.size(), 0);
`ifdef BANDIT_ENV_NOISE_EN
        check("saturation_hit_max", seen_max, 1);
        check("saturation_hit_min", seen_min, 1);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
